// File: rtl/adc_buf_pkg.sv
// Shared types for the ADC trigger-window buffer: event descriptor, FSM states.
// Optional feature macro: ADC_BUF_TSTAMP_EN adds a 32-bit trigger timestamp.
package adc_buf_pkg;

  localparam int TSTAMP_W = 32;
  // Descriptor address/length fields are sized for the largest supported ring.
  localparam int DESC_FW  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } adc_buf_state_e;

  typedef struct packed {
`ifdef ADC_BUF_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;
`endif
    logic [DESC_FW-1:0]  start;
    logic [DESC_FW-1:0]  len;
  } adc_evt_desc_t;

endpackage

// File: rtl/adc_evt_fifo.sv
// Small synchronous show-ahead FIFO used to queue event descriptors.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module adc_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage, not reset.
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end

endmodule

// File: rtl/adc_trig_window_buf.sv
// Trigger-window event buffer: circular multi-channel sample store, descriptor
// queue per trigger, and a valid/ready window readout with a 2-entry skid.
// Optional feature macro: ADC_BUF_TSTAMP_EN (trigger timestamp on rd_tstamp).
module adc_trig_window_buf
  import adc_buf_pkg::*;
#(
  parameter int NUM_CH   = 64,
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 128,
  parameter int MAX_WIN  = 32,
  parameter int NUM_EVT  = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int WW = $clog2(MAX_WIN+1),
  localparam int PW = $clog2(NUM_EVT+1)
) (
  input  logic                             adc_clk,
  input  logic                             rst_n,
  input  logic                             adc_valid,
  input  logic [NUM_CH-1:0][SAMPLE_W-1:0]  adc_data,
  input  logic                             trig_l0,
  input  logic [AW-1:0]                    trigger_latency,
  input  logic [WW-1:0]                    win_len,
  output logic                             rd_valid,
  input  logic                             rd_ready,
  output logic [NUM_CH-1:0][SAMPLE_W-1:0]  rd_data,
  output logic                             rd_last,
`ifdef ADC_BUF_TSTAMP_EN
  output logic [TSTAMP_W-1:0]              rd_tstamp,
`endif
  output logic [PW-1:0]                    evt_pending,
  output logic [15:0]                      trig_drop_cnt,
  output logic                             overrun,
  output logic                             busy
);

  logic [NUM_CH-1:0][SAMPLE_W-1:0] ram [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_addr, trig_start;
  logic [WW-1:0]   remaining, rd_rem, trig_len;
  adc_buf_state_e  state, state_nx;
  adc_evt_desc_t   push_desc, cur_desc, fifo_dout;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty, trig_drop;
  logic            issue, issue_last, space, beat_acc, head_last;
  logic            rq_vld, rq_last, sk_vld, sk_last;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] rq_data, sk_data;
  logic            unused_desc_bits;

  assign unused_desc_bits = ^{cur_desc.start[DESC_FW-1:AW], cur_desc.len[DESC_FW-1:WW]};

  // Ring write port, not reset (block-RAM friendly).
  always_ff @(posedge adc_clk)
    if (adc_valid) ram[wr_ptr] <= adc_data;

  // Write pointer advances once per accepted sample, wrapping naturally.
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) wr_ptr <= '0;
    else if (adc_valid) wr_ptr <= wr_ptr + AW'(1);

`ifdef ADC_BUF_TSTAMP_EN
  logic [TSTAMP_W-1:0] tstamp_cnt;
  // Free-running sample timestamp.
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) tstamp_cnt <= '0;
    else if (adc_valid) tstamp_cnt <= tstamp_cnt + TSTAMP_W'(1);
  assign rd_tstamp = cur_desc.tstamp;
`endif

  assign trig_start = wr_ptr - trigger_latency;

  // Coerce the requested window length into 1..MAX_WIN and build the descriptor.
  always_comb begin
    trig_len = win_len;
    if (win_len == '0) trig_len = WW'(1);
    else if (win_len > WW'(MAX_WIN)) trig_len = WW'(MAX_WIN);
    push_desc       = '0;
    push_desc.start = DESC_FW'(trig_start);
    push_desc.len   = DESC_FW'(trig_len);
`ifdef ADC_BUF_TSTAMP_EN
    push_desc.tstamp = tstamp_cnt;
`endif
  end

  assign fifo_push = trig_l0 & (~fifo_full | fifo_pop);
  assign trig_drop = trig_l0 & fifo_full & ~fifo_pop;

  adc_evt_fifo #(.WIDTH($bits(adc_evt_desc_t)), .DEPTH(NUM_EVT)) u_evt_fifo (
    .clk   (adc_clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (push_desc),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (evt_pending)
  );

  // Saturating dropped-trigger counter.
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) trig_drop_cnt <= '0;
    else if (trig_drop && trig_drop_cnt != 16'hFFFF) trig_drop_cnt <= trig_drop_cnt + 16'd1;

  // Output side: skid entry is always older than the RAM output register.
  assign rd_valid  = sk_vld | rq_vld;
  assign head_last = sk_vld ? sk_last : rq_last;
  assign rd_last   = rd_valid & head_last;
  assign rd_data   = sk_vld ? sk_data : (rq_vld ? rq_data : '0);
  assign beat_acc  = rd_valid & rd_ready;
  assign space     = ~(sk_vld & rq_vld);

  // LOAD issues the first read straight from the descriptor to save a cycle.
  assign rd_addr    = (state == LOAD) ? cur_desc.start[AW-1:0] : rd_ptr;
  assign rd_rem     = (state == LOAD) ? cur_desc.len[WW-1:0]   : remaining;
  assign issue      = (state == LOAD || state == STREAM) && (rd_rem != '0) &&
                      (rd_addr != wr_ptr) && space;
  assign issue_last = issue && (rd_rem == WW'(1));
  assign busy       = (state != IDLE);

  // FSM state register.
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // FSM next state and descriptor pop.
  always_comb begin
    state_nx = state;
    fifo_pop = 1'b0;
    case (state)
      IDLE:   if (!fifo_empty) begin
                fifo_pop = 1'b1;
                state_nx = LOAD;
              end
      LOAD:   state_nx = STREAM;
      STREAM: if (remaining == '0 && beat_acc && head_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Current descriptor, read pointer and beats-to-issue.
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) begin
      cur_desc  <= '0;
      rd_ptr    <= '0;
      remaining <= '0;
    end else begin
      if (fifo_pop) cur_desc <= fifo_dout;
      if (state == LOAD || state == STREAM) begin
        rd_ptr    <= rd_addr + AW'(issue);
        remaining <= rd_rem - WW'(issue);
      end
    end

  // RAM read port; its output register doubles as the first skid entry.
  always_ff @(posedge adc_clk)
    if (issue) rq_data <= ram[rd_addr];

  // Two-entry skid control: spill the RAM register when a new read lands on it.
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) begin
      rq_vld  <= 1'b0;
      rq_last <= 1'b0;
      sk_vld  <= 1'b0;
      sk_last <= 1'b0;
      sk_data <= '0;
    end else begin
      if (issue) begin
        rq_vld  <= 1'b1;
        rq_last <= issue_last;
      end else if (!sk_vld && beat_acc) begin
        rq_vld  <= 1'b0;
      end
      if (sk_vld && beat_acc) begin
        sk_vld <= 1'b0;
      end else if (!sk_vld && rq_vld && !beat_acc && issue) begin
        sk_vld  <= 1'b1;
        sk_data <= rq_data;
        sk_last <= rq_last;
      end
    end

  // Sticky overrun: writer is about to land on a sample not yet issued.
  always_ff @(posedge adc_clk or negedge rst_n)
    if (!rst_n) overrun <= 1'b0;
    else if (adc_valid && state == STREAM && remaining != '0 &&
             wr_ptr == rd_ptr - AW'(1))
      overrun <= 1'b1;

endmodule

// File: tb/tb_adc_trig_window_buf.sv
// Scoreboard bench for adc_trig_window_buf: stimulus pushes expected beats,
// a negedge monitor pops and compares on every accepted beat.
module tb_adc_trig_window_buf;
  localparam int NUM_CH = 64, SAMPLE_W = 12, DEPTH = 128, MAX_WIN = 32, NUM_EVT = 4;
  localparam int AW = $clog2(DEPTH), WW = $clog2(MAX_WIN+1), PW = $clog2(NUM_EVT+1);

  typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] word_t;
  typedef struct {
    logic [SAMPLE_W-1:0] val;
    logic                last;
    logic [31:0]         ts;
  } exp_t;

  logic adc_clk, rst_n, adc_valid, trig_l0, rd_valid, rd_ready, rd_last, overrun, busy;
  word_t adc_data, rd_data;
  logic [AW-1:0] trigger_latency;
  logic [WW-1:0] win_len;
  logic [PW-1:0] evt_pending;
  logic [15:0]   trig_drop_cnt;
`ifdef ADC_BUF_TSTAMP_EN
  logic [31:0]   rd_tstamp;
`endif

  adc_trig_window_buf #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH),
                        .MAX_WIN(MAX_WIN), .NUM_EVT(NUM_EVT)) dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
    .trig_l0(trig_l0), .trigger_latency(trigger_latency), .win_len(win_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
`ifdef ADC_BUF_TSTAMP_EN
    .rd_tstamp(rd_tstamp),
`endif
    .evt_pending(evt_pending), .trig_drop_cnt(trig_drop_cnt), .overrun(overrun), .busy(busy)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  exp_t sb[$];
  int   errs = 0, checks = 0, s_cnt = 0, rdy_mode = 0;

  function automatic word_t fill(input logic [SAMPLE_W-1:0] v);
    word_t w;
    for (int i = 0; i < NUM_CH; i++) w[i] = v;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One stimulus cycle; a trigger pushes the expected window into the scoreboard.
  task automatic cyc(input bit v, input bit t = 0, input int lat = 0, input int len = 0,
                     input bit acc = 1);
    int eff;
    adc_valid = v;
    adc_data = fill(SAMPLE_W'(s_cnt));
    trig_l0 = t;
    trigger_latency = AW'(lat);
    win_len = WW'(len);
    if (t && acc) begin
      eff = (len == 0) ? 1 : ((len > MAX_WIN) ? MAX_WIN : len);
      for (int k = 0; k < eff; k++)
        sb.push_back('{val: SAMPLE_W'(s_cnt - lat + k), last: (k == eff-1), ts: 32'(s_cnt)});
    end
    @(posedge adc_clk); #1;
    if (v) s_cnt++;
    trig_l0 = 1'b0;
  endtask

  task automatic drain(input string nm, input bit alt = 0);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      cyc(alt ? ~n[0] : 1'b1);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errs++;
      $display("FAIL %s drain timeout: %0d beats outstanding, expected 0", nm, sb.size());
    end
    repeat (3) cyc(1);
  endtask

  // Ready driver.
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge adc_clk); #1;
      case (rdy_mode)
        1:       rd_ready = 1'($urandom_range(0, 1));
        2:       rd_ready = 1'b0;
        default: rd_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare accepted beats and check stability while stalled.
  initial begin
    exp_t  e;
    bit    stall_q = 0;
    word_t data_q;
    logic  last_q;
    forever begin
      @(negedge adc_clk);
      if (!rst_n) stall_q = 0;
      else begin
        if (stall_q) begin
          checks++;
          if (!rd_valid || rd_data !== data_q || rd_last !== last_q) begin
            errs++;
            $display("FAIL hold: valid=%b ch0=%0h last=%b, expected valid=1 ch0=%0h last=%b",
                     rd_valid, rd_data[0], rd_last, data_q[0], last_q);
          end
        end
        if (rd_valid && rd_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errs++;
            $display("FAIL beat: unexpected beat ch0=%0h, expected none", rd_data[0]);
          end else begin
            e = sb.pop_front();
            if (rd_data !== fill(e.val) || rd_last !== e.last) begin
              errs++;
              $display("FAIL beat: ch0=%0h ch63=%0h last=%b, expected all=%0h last=%b",
                       rd_data[0], rd_data[NUM_CH-1], rd_last, e.val, e.last);
            end
`ifdef ADC_BUF_TSTAMP_EN
            checks++;
            if (rd_tstamp !== e.ts) begin
              errs++;
              $display("FAIL tstamp: got %0d expected %0d", rd_tstamp, e.ts);
            end
`endif
          end
        end
        stall_q = rd_valid && !rd_ready;
        data_q  = rd_data;
        last_q  = rd_last;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; adc_valid = 1'b0; trig_l0 = 1'b0; adc_data = '0;
    trigger_latency = '0; win_len = '0;
    repeat (3) @(posedge adc_clk);
    #1;
    chk("rst_valid", rd_valid, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_data", 32'(rd_data != '0), 0);
    chk("rst_pending", evt_pending, 0);
    chk("rst_drop", trig_drop_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Basic window: trigger at sample 100, latency 48, 16 beats of 52..67.
    while (s_cnt < 100) cyc(1);
    cyc(1, 1, 48, 16);
    chk("t1_valid", rd_valid, 0);
    chk("t1_pending", evt_pending, 1);
    chk("t1_busy", busy, 0);
    cyc(1);
    chk("t2_valid", rd_valid, 0);
    chk("t2_busy", busy, 1);
    chk("t2_pending", evt_pending, 0);
    cyc(1);
    chk("t3_valid", rd_valid, 1);
    chk("t3_data", rd_data[0], 52);
    drain("basic");

    // Wrap-around: wr_ptr 5, latency 10 -> start address 123.
    while ((s_cnt % DEPTH) != 5) cyc(1);
    cyc(1, 1, 10, 16);
    drain("wrap");

    // Length coercion: 0 -> 1 beat, 40 -> MAX_WIN beats.
    cyc(1, 1, 40, 0);
    drain("len0");
    cyc(1, 1, 50, 40);
    drain("len_clamp");

    // Random back-pressure with a second event queued mid-stream.
    rdy_mode = 1;
    cyc(1, 1, 60, 20);
    repeat (5) cyc(1);
    cyc(1, 1, 30, 10);
    drain("backpressure");
    rdy_mode = 0;

    // Derandomiser: 6 triggers 2 cycles apart with readout stalled.
    rdy_mode = 2;
    repeat (2) cyc(1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 30 + i, 4, i < 5);
      cyc(1);
    end
    chk("derand_pending", evt_pending, 4);
    chk("derand_drop", trig_drop_cnt, 1);
    chk("derand_busy", busy, 1);
    rdy_mode = 0;
    drain("derand");
    chk("derand_drop_after", trig_drop_cnt, 1);

    // Latency smaller than window: stream catches the writer and stalls.
    cyc(1, 1, 2, 8);
    drain("short_lat", 1'b1);
    chk("pre_overrun", overrun, 0);

    // Overrun: stalled readout lapped by the writer.
    rdy_mode = 2;
    repeat (2) cyc(1);
    cyc(1, 1, 100, 32, 0);
    repeat (200) cyc(1);
    chk("overrun_set", overrun, 1);
    repeat (20) cyc(1);
    chk("overrun_sticky", overrun, 1);

    // Reset mid-event: everything clears, no stray beats afterwards.
    rst_n = 1'b0;
    #1;
    sb.delete();
    s_cnt = 0;
    chk("rst2_overrun", overrun, 0);
    chk("rst2_valid", rd_valid, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_drop", trig_drop_cnt, 0);
    repeat (2) cyc(0);
    rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0);
      chk("post_rst_valid", rd_valid, 0);
    end
    chk("post_rst_pending", evt_pending, 0);

    // Event after reset proves the write pointer restarted at 0.
    while (s_cnt < 20) cyc(1);
    cyc(1, 1, 10, 4);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
